// File: rtl/reflet_int_ctrl_pkg.sv
// Shared definitions for the reflet interrupt controller: parameter defaults,
// trigger-mode encoding and the fixed-priority helper.
package reflet_int_ctrl_pkg;

    localparam int unsigned DEF_WORDSIZE      = 16;
    localparam int unsigned DEF_INT_COUNT     = 8;
    localparam int unsigned DEF_NEST_DEPTH    = 4;
    localparam int unsigned DEF_VECTOR_BASE   = 16;
    localparam int unsigned DEF_VECTOR_STRIDE = 4;

    typedef enum logic {
        TRIG_EDGE  = 1'b0,
        TRIG_LEVEL = 1'b1
    } trig_mode_e;

    // Index of the lowest set bit (line 0 is highest priority); 0 when none set.
    function automatic logic [3:0] first_set(input logic [15:0] v);
        logic found;
        first_set = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i] && !found) begin
                first_set = 4'(i);
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/reflet_int_stack.sv
// Return-PC LIFO for nested interrupts; entry 0 is always the top of stack,
// so push/pop shift the whole array and no pointer indexing is needed.
module reflet_int_stack
    import reflet_int_ctrl_pkg::*;
#(
    parameter int unsigned width    = DEF_WORDSIZE,
    parameter int unsigned id_width = 3,
    parameter int unsigned depth    = DEF_NEST_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [width-1:0]               push_pc,
    input  logic [id_width-1:0]            push_id,
    output logic [width-1:0]               top_pc,
    output logic [id_width-1:0]            top_id,
    output logic [$clog2(depth+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned CW = $clog2(depth + 1);

    typedef struct packed {
        logic [width-1:0]    pc;
        logic [id_width-1:0] id;
    } frame_t;

    frame_t st [depth];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < depth; i++) st[i] <= '0;
            count <= '0;
        end else if (push) begin
            st[0] <= '{pc: push_pc, id: push_id};
            for (int unsigned i = 1; i < depth; i++) st[i] <= st[i-1];
            count <= count + 1'b1;
        end else if (pop) begin
            for (int unsigned i = 0; i + 1 < depth; i++) st[i] <= st[i+1];
            st[depth-1] <= '0;
            count <= count - 1'b1;
        end
    end

    assign top_pc = st[0].pc;
    assign top_id = st[0].id;
    assign full   = (count == CW'(depth));
    assign empty  = (count == '0);

endmodule

// File: rtl/reflet_int_ctrl.sv
// Interrupt controller for the reflet CPU: synchronised edge/level request lines,
// fixed priority, nested preemption with a return-PC stack.
module reflet_int_ctrl
    import reflet_int_ctrl_pkg::*;
#(
    parameter int unsigned wordsize      = DEF_WORDSIZE,
    parameter int unsigned int_count     = DEF_INT_COUNT,
    parameter int unsigned nest_depth    = DEF_NEST_DEPTH,
    parameter int unsigned vector_base   = DEF_VECTOR_BASE,
    parameter int unsigned vector_stride = DEF_VECTOR_STRIDE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [int_count-1:0]              ext_int,
    input  logic [int_count-1:0]              int_mask,
    input  logic [int_count-1:0]              level_mode,
    input  logic                              cpu_update,
    input  logic [wordsize-1:0]               program_counter,
    input  logic                              retint,
    input  logic                              setint,
    input  logic [$clog2(int_count)-1:0]      setint_id,
    // 'int' is a reserved word in SystemVerilog, so the take-interrupt strobe is intr
    output logic                              intr,
    output logic [wordsize-1:0]               out_routine,
    output logic [wordsize-1:0]               return_pc,
    output logic [$clog2(nest_depth+1)-1:0]   depth,
    output logic                              err_underflow
);

    localparam int unsigned IDW = $clog2(int_count);

    logic [int_count-1:0] sync1, sync2, prev;
    logic [int_count-1:0] pending, pending_nx;
    logic [int_count-1:0] req, rise;
    logic [IDW-1:0]       cand, cur;
    logic [wordsize-1:0]  top_pc;
    logic                 full, empty, eligible, strobe, ret_ok, pop;

    // Synchroniser keeps running while disabled so re-enable sees no stale edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= ext_int;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise     = sync2 & ~prev;
    assign req      = pending & int_mask;
    assign cand     = IDW'(first_set(16'(req)));
    assign strobe   = enable & cpu_update;
    assign ret_ok   = strobe & retint;
    assign eligible = (req != '0) && !full && (empty || (cand < cur));
    assign intr     = strobe & eligible & ~retint;
    assign pop      = ret_ok & ~empty;

    // A new edge or setint landing on the line being granted survives the clear.
    always_comb begin
        pending_nx = pending;
        for (int unsigned i = 0; i < int_count; i++) begin
            logic sw;
            sw = strobe && setint && (setint_id == IDW'(i));
            if (level_mode[i] == TRIG_LEVEL)
                pending_nx[i] = sync2[i] | sw;
            else
                pending_nx[i] = (pending[i] & ~(intr && (cand == IDW'(i)))) | rise[i] | sw;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending       <= '0;
            err_underflow <= 1'b0;
        end else if (enable) begin
            pending <= pending_nx;
            if (ret_ok && empty) err_underflow <= 1'b1;
        end
    end

    reflet_int_stack #(
        .width    (wordsize),
        .id_width (IDW),
        .depth    (nest_depth)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (intr),
        .pop     (pop),
        .push_pc (program_counter),
        .push_id (cand),
        .top_pc  (top_pc),
        .top_id  (cur),
        .count   (depth),
        .full    (full),
        .empty   (empty)
    );

    assign out_routine = wordsize'(vector_base) + wordsize'(cand) * wordsize'(vector_stride);
    assign return_pc   = empty ? '0 : top_pc;

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Self-checking bench for reflet_int_ctrl: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_reflet_int_ctrl;

    localparam int N  = 8;
    localparam int ND = 4;
    localparam int VB = 16;
    localparam int VS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, cpu_update, retint, setint;
    logic [7:0]  ext_int, int_mask, level_mode;
    logic [15:0] program_counter;
    logic [2:0]  setint_id;
    logic        intr;
    logic [15:0] out_routine, return_pc;
    logic [2:0]  depth;
    logic        err_underflow;

    reflet_int_ctrl #(
        .wordsize      (16),
        .int_count     (N),
        .nest_depth    (ND),
        .vector_base   (VB),
        .vector_stride (VS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .ext_int         (ext_int),
        .int_mask        (int_mask),
        .level_mode      (level_mode),
        .cpu_update      (cpu_update),
        .program_counter (program_counter),
        .retint          (retint),
        .setint          (setint),
        .setint_id       (setint_id),
        .intr            (intr),
        .out_routine     (out_routine),
        .return_pc       (return_pc),
        .depth           (depth),
        .err_underflow   (err_underflow)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Staged stimulus, applied at the next falling edge.
    logic        s_en, s_upd, s_ret, s_set;
    logic [7:0]  s_ext, s_mask, s_lvl;
    logic [15:0] s_pc;
    logic [2:0]  s_sid;

    // Reference model: pending bits, return stack as a queue, input history.
    typedef struct {
        logic [15:0] pc;
        int          id;
    } frame_t;
    frame_t     stk[$];
    bit         m_pend[N];
    bit         m_err;
    logic [7:0] h[3];   // h[0]=ext one cycle back, h[1]=two back, h[2]=three back

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 3; i++) h[i] = '0;
    endtask

    task automatic tick();
        int     cand, d, c0;
        bit     elig, e_int, sw;
        frame_t f;
        @(negedge clk);
        enable = s_en; cpu_update = s_upd; retint = s_ret; setint = s_set;
        ext_int = s_ext; int_mask = s_mask; level_mode = s_lvl;
        program_counter = s_pc; setint_id = s_sid;
        #1;
        cand = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && int_mask[i] && cand < 0) cand = i;
        d     = stk.size();
        elig  = (cand >= 0) && (d < ND) && (d == 0 || cand < stk[d-1].id);
        e_int = enable && cpu_update && elig && !retint;
        c0    = (cand < 0) ? 0 : cand;
        check_eq("int", intr, e_int);
        check_eq("out_routine", out_routine, 16'(VB + c0 * VS));
        check_eq("return_pc", return_pc, (d > 0) ? stk[d-1].pc : 16'h0);
        check_eq("depth", depth, d);
        check_eq("err_underflow", err_underflow, m_err);
        if (enable) begin
            if (e_int) begin
                f.pc = program_counter;
                f.id = cand;
                stk.push_back(f);
            end
            if (cpu_update && retint) begin
                if (d > 0) void'(stk.pop_back());
                else m_err = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                sw = cpu_update && setint && (int'(setint_id) == i);
                if (level_mode[i])
                    m_pend[i] = h[1][i] || sw;
                else
                    m_pend[i] = (m_pend[i] && !(e_int && cand == i)) || (h[1][i] && !h[2][i]) || sw;
            end
        end
        h[2] = h[1];
        h[1] = h[0];
        h[0] = ext_int;
    endtask

    task automatic stage_idle();
        s_en = 1'b1; s_upd = 1'b1; s_ret = 1'b0; s_set = 1'b0;
        s_ext = '0; s_mask = '1; s_lvl = '0; s_pc = 16'h0100; s_sid = '0;
    endtask

    // Async reset asserted between clock edges, released just after a rising edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_int", intr, 1'b0);
        check_eq("rst_depth", depth, 3'd0);
        check_eq("rst_err", err_underflow, 1'b0);
        check_eq("rst_rpc", return_pc, 16'h0);
        model_reset();
        stage_idle();
        ext_int = '0; retint = 1'b0; setint = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0; cpu_update = 1'b0; retint = 1'b0; setint = 1'b0;
        ext_int = '0; int_mask = '0; level_mode = '0; program_counter = '0; setint_id = '0;
        stage_idle();
        model_reset();
        #12;
        check_eq("rst_routine", out_routine, 16'(VB));
        pulse_reset();

        // Edge line 3: grant three cycles after the rise.
        s_ext[3] = 1'b1;
        repeat (4) tick();
        check_eq("s1_int", intr, 1'b1);
        check_eq("s1_vec", out_routine, 16'd28);
        tick();
        check_eq("s1_depth", depth, 3'd1);
        s_ext = '0; s_ret = 1'b1; tick(); s_ret = 1'b0; tick();

        // Line 5 in service, line 2 preempts and pushes 0x0040.
        s_ext[5] = 1'b1;
        repeat (4) tick();
        s_pc = 16'h0040; s_ext[2] = 1'b1;
        repeat (4) tick();
        check_eq("s2_preempt", intr, 1'b1);
        tick();
        check_eq("s2_depth", depth, 3'd2);
        s_ret = 1'b1; tick();
        check_eq("s2_rpc", return_pc, 16'h0040);
        s_ret = 1'b0; tick();
        check_eq("s2_depth_back", depth, 3'd1);
        s_ret = 1'b1; tick(); s_ret = 1'b0; s_ext = '0; tick();

        // Lower-priority line 6 waits for line 2 to return.
        s_ext[2] = 1'b1;
        repeat (4) tick();
        s_ext[6] = 1'b1;
        repeat (6) tick();
        check_eq("s3_held", intr, 1'b0);
        s_ret = 1'b1; tick(); s_ret = 1'b0; tick();
        check_eq("s3_grant", intr, 1'b1);
        check_eq("s3_vec", out_routine, 16'd40);
        tick();
        s_ret = 1'b1; tick(); s_ret = 1'b0; s_ext = '0; tick();

        // Fill the stack 7,5,3,1; line 0 must wait until one return.
        for (int k = 0; k < 4; k++) begin
            s_ext[7 - 2 * k] = 1'b1;
            repeat (4) tick();
        end
        s_ext[0] = 1'b1;
        repeat (6) tick();
        check_eq("s4_full_hold", intr, 1'b0);
        check_eq("s4_full_depth", depth, 3'd4);
        s_ret = 1'b1; tick(); s_ret = 1'b0; tick();
        check_eq("s4_grant0", intr, 1'b1);
        check_eq("s4_vec0", out_routine, 16'd16);
        tick();
        s_ret = 1'b1; tick(); s_ret = 1'b0;
        check_eq("s4_depth3", depth, 3'd4);
        tick();
        check_eq("s4_depth3b", depth, 3'd3);
        #2;
        pulse_reset();

        // Underflow is sticky; a held level line re-grants after its return.
        s_ret = 1'b1; tick(); s_ret = 1'b0; tick();
        check_eq("s5_err", err_underflow, 1'b1);
        check_eq("s5_depth", depth, 3'd0);
        s_lvl[4] = 1'b1; s_ext[4] = 1'b1;
        repeat (4) tick();
        check_eq("s5_level_int", intr, 1'b1);
        s_ret = 1'b1; tick(); s_ret = 1'b0; tick();
        check_eq("s5_level_regrant", intr, 1'b1);
        s_ext = '0;
        repeat (3) begin s_ret = 1'b1; tick(); s_ret = 1'b0; tick(); end

        // Randomized traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) begin
                s_mask = 8'($urandom | $urandom);
                s_lvl  = 8'($urandom & $urandom);
            end
            s_en  = ($urandom_range(0, 19) != 0);
            s_upd = ($urandom_range(0, 3) != 0);
            s_ret = ($urandom_range(0, 6) == 0);
            s_set = ($urandom_range(0, 9) == 0);
            s_sid = 3'($urandom);
            s_pc  = 16'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) s_ext[i] = ~s_ext[i];
            tick();
            if (cyc == 2000) begin
                #3;
                pulse_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
